csa_serial_sub: RTL and testbench

Iterative N-bit subtractor that computes D = A − B − bin one 4-bit slice per clock using a carry-skip slice, with valid/ready handshakes on both sides. It is the subtract-direction companion to the team's combinational carry-skip adder. It trades throughput for area in the datapath: one slice of hardware is reused N/4 times. It produces the difference, the borrow out and the signed-overflow flag.

---
 rtl/csa_pkg.sv | 19 +
 rtl/csa_serial_sub_if.sv | 30 +++
 rtl/csa_slice4.sv | 29 ++
 rtl/csa_serial_sub.sv | 94 +++++++++
 tb/tb_csa_serial_sub.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared types and constants for the serial carry-skip subtractor.
package csa_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Slice-counter width for an n-bit operand; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n / SLICE_W);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/csa_serial_sub_if.sv
// Operand and result handshake bundle for csa_serial_sub.
interface csa_serial_sub_if #(
  parameter int N = 32
);

  // Both channels use valid/ready: a transfer occurs on a rising clk edge where
  // valid && ready; the producer holds valid and its data stable until then.
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         of;
  logic         busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, of, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, of, busy
  );

endinterface

// File: rtl/csa_slice4.sv
// Combinational 4-bit carry-skip adder slice: {co, s} = x + y + ci.
module csa_slice4
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  always_comb begin
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s  = p ^ c[SLICE_W-1:0];
    // When every bit propagates, the carry-in bypasses the ripple chain.
    co = (&p) ? ci : c[SLICE_W];
  end

endmodule

// File: rtl/csa_serial_sub.sv
// Iterative subtractor: diff = a - b - bin, one 4-bit carry-skip slice per clock.
module csa_serial_sub
  import csa_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  csa_serial_sub_if.slave   bus,
  output state_t            state
);

  localparam int              NS     = N / SLICE_W;
  localparam int              CW     = cnt_width(N);
  localparam logic [CW-1:0]   K_LAST = CW'(NS - 1);

  state_t               state_q;
  logic [N-1:0]         a_q;
  logic [N-1:0]         b_q;
  logic [N-1:0]         diff_q;
  logic                 c_q;
  logic                 bout_q;
  logic                 of_q;
  logic [CW-1:0]        k_q;

  logic [SLICE_W-1:0]   x_s;
  logic [SLICE_W-1:0]   y_s;
  logic [SLICE_W-1:0]   s_s;
  logic                 co_s;

  // Subtraction runs as a + ~b + c, with the carry seeded from ~bin.
  assign x_s = a_q[int'(k_q)*SLICE_W +: SLICE_W];
  assign y_s = ~b_q[int'(k_q)*SLICE_W +: SLICE_W];

  csa_slice4 u_slice (
    .x  (x_s),
    .y  (y_s),
    .ci (c_q),
    .s  (s_s),
    .co (co_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
      of_q    <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            c_q     <= ~bus.bin;
            k_q     <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          diff_q[int'(k_q)*SLICE_W +: SLICE_W] <= s_s;
          c_q <= co_s;
          if (k_q == K_LAST) begin
            // The top slice's sum bit is the final diff MSB.
            bout_q  <= ~co_s;
            of_q    <= (a_q[N-1] ^ b_q[N-1]) & (s_s[SLICE_W-1] ^ a_q[N-1]);
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.of        = of_q;
  assign state         = state_q;

endmodule

// File: tb/tb_csa_serial_sub.sv
// Self-checking bench for csa_serial_sub (N = 32): vector table, corner sequences, random traffic.
module tb_csa_serial_sub;
  import csa_pkg::*;

  localparam int N     = 32;
  localparam int NRAND = 1000;

  logic   clk;
  logic   rst;
  state_t state;

  int checks = 0;
  int errors = 0;

  csa_serial_sub_if #(.N(N)) bus ();

  csa_serial_sub #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] exp_diff;
    logic        exp_bout;
    logic        exp_of;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic on the operands.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] u;
    longint      sd;
    logic        o;
    u  = {1'b0, a} - {1'b0, b} - 33'(bin);
    sd = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {u[32], o, u[31:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Driver: one full transaction with out_ready held high; reports latency from accept edge.
  task automatic run_vec(input logic [31:0] a_v, input logic [31:0] b_v, input logic bin_v,
                         output logic [31:0] d, output logic bo, output logic o, output int lat);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = a_v;
    bus.b         = b_v;
    bus.bin       = bin_v;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("in_ready_in_run", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = bus.diff;
    bo = bus.bout;
    o  = bus.of;
    @(posedge clk); #1;
    check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d, d0;
    logic        bo, o, bo0, o0;
    int          lat;
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic        acc, hs;
    int          sent, recv, cyc;

    vecs[0] = '{32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h10,         32'h0F,         1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'd100,        32'd58,         1'b0, 32'd42,        1'b0, 1'b0};
    vecs[6] = '{32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[8] = '{32'd0,          32'h8000_0000,  1'b0, 32'h8000_0000, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_diff",      bus.diff,           32'd0);
    check("rst_bout",      32'(bus.bout),      32'd0);
    check("rst_of",        32'(bus.of),        32'd0);
    check("rst_state",     32'(state),         32'(S_IDLE));

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, o, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_diff", i), d, vecs[i].exp_diff);
      check($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].exp_bout));
      check($sformatf("vec%0d_of", i), 32'(o), 32'(vecs[i].exp_of));
    end

    // Backpressure: result held in DONE while in_valid is ignored.
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'h0000_1234;
    bus.b         = 32'h0000_0034;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd8);
    d0  = bus.diff;
    bo0 = bus.bout;
    o0  = bus.of;
    check("bp_diff", d0, 32'h0000_1200);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk); #1;
      check("bp_hold_diff",      bus.diff,           d0);
      check("bp_hold_bout",      32'(bus.bout),      32'(bo0));
      check("bp_hold_of",        32'(bus.of),        32'(o0));
      check("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_no_stale_start", 32'(state), 32'(S_IDLE));

    // Reset in the middle of RUN at slice k = 3.
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'h1234_5678;
    bus.b         = 32'h0101_0101;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_state", 32'(state), 32'(S_RUN));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_state",     32'(state),         32'(S_IDLE));
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy",      32'(bus.busy),      32'd0);
    check("mid_rst_diff",      bus.diff,           32'd0);
    check("mid_rst_bout",      32'(bus.bout),      32'd0);
    check("mid_rst_of",        32'(bus.of),        32'd0);
    run_vec(32'd100, 32'd58, 1'b0, d, bo, o, lat);
    check("post_rst_latency", 32'(lat), 32'd8);
    check("post_rst_diff",    d,        32'd42);

    // Random traffic with a scoreboard; producer holds valid until accepted.
    sent = 0;
    recv = 0;
    cyc  = 0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    while ((sent < NRAND || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      if (acc) begin
        exp_q.push_back(model(bus.a, bus.b, bus.bin));
        sent++;
      end
      if (hs) begin
        recv++;
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_diff", bus.diff,      e[31:0]);
          check("rand_bout", 32'(bus.bout), 32'(e[33]));
          check("rand_of",   32'(bus.of),   32'(e[32]));
        end
      end
      @(posedge clk); #1;
      if (acc || !bus.in_valid) begin
        if (sent < NRAND && $urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1;
          bus.a        = rand_op();
          bus.b        = rand_op();
          bus.bin      = 1'($urandom_range(0, 1));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    check("rand_sent",    32'(sent),         32'(NRAND));
    check("rand_recv",    32'(recv),         32'(NRAND));
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
